if_stage_2way: RTL and testbench

- Two-wide instruction fetch stage. Produces the per-slot PC/NPC/IR/target/valid bundle consumed by the fetch buffer.
- Owns the architectural fetch PC and issues one aligned 64-bit I-cache read per cycle; each read holds two 32-bit instructions.
- Advances only when the fetch buffer asserts fetch_en. Redirects on rollback and parks after fetching a HALT.

---
 rtl/if_stage_2way.sv | 117 +++++++++++
 tb/tb_if_stage_2way.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_2way.sv
// Two-wide fetch stage: aligned 64-bit I-cache read, per-slot bundle, HALT park.
// Optional static BR/BSR predecode is enabled by defining IF_PREDECODE_EN.
module if_stage_2way #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] HALT_INST = 32'h0000_0555
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             fetch_en,
  input  logic             rollback_en,
  input  logic [63:0]      rollback_PC,
  input  logic [63:0]      Icache_data_in,
  input  logic             Icache_valid_in,
  output logic [63:0]      Icache_PC_out,
  output logic [1:0][63:0] if_PC_out,
  output logic [1:0][63:0] if_NPC_out,
  output logic [1:0][31:0] if_IR_out,
  output logic [1:0][63:0] if_target_out,
  output logic [1:0]       if_valid_inst_out,
  output logic             halted
);

  typedef enum logic {FETCH, HALTED} state_t;

  state_t      state, state_nx;
  logic [63:0] pc, pc_nx;
  logic [1:0]  base_v;
  logic        kill_s1;
  logic        accept;
  logic        halt_hit;
  logic        unused_pc;

  assign unused_pc = ^pc[1:0];
  assign halted    = (state == HALTED);

  always_comb begin
    Icache_PC_out = {pc[63:3], 3'b000};
    if_PC_out[0]  = Icache_PC_out;
    if_PC_out[1]  = Icache_PC_out + 64'd4;
    if_IR_out[0]  = Icache_data_in[31:0];
    if_IR_out[1]  = Icache_data_in[63:32];
    for (int i = 0; i < 2; i++) begin
      if_NPC_out[i] = if_PC_out[i] + 64'd4;
    end
  end

  always_comb begin
    base_v = 2'b00;
    if (!halted && !rollback_en && Icache_valid_in) begin
      base_v = pc[2] ? 2'b10 : 2'b11;
    end
  end

`ifdef IF_PREDECODE_EN
  logic [1:0] taken;
  logic [5:0] opc [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      opc[i]   = if_IR_out[i][31:26];
      taken[i] = base_v[i] && (opc[i] == 6'h30 || opc[i] == 6'h34);
      if_target_out[i] = if_NPC_out[i];
      if (taken[i]) begin
        if_target_out[i] = if_NPC_out[i]
          + {{41{if_IR_out[i][20]}}, if_IR_out[i][20:0], 2'b00};
      end
    end
  end

  assign kill_s1 = base_v[0]
    && (if_IR_out[0] == HALT_INST || taken[0]);
`else
  assign if_target_out = if_NPC_out;
  assign kill_s1 = base_v[0] && (if_IR_out[0] == HALT_INST);
`endif

  always_comb begin
    if_valid_inst_out = base_v;
    if (kill_s1) if_valid_inst_out[1] = 1'b0;
  end

  assign accept = en && fetch_en && !rollback_en
    && (if_valid_inst_out != 2'b00);

  assign halt_hit =
    (if_valid_inst_out[0] && if_IR_out[0] == HALT_INST) ||
    (if_valid_inst_out[1] && if_IR_out[1] == HALT_INST);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= FETCH;
    end else begin
      pc    <= pc_nx;
      state <= state_nx;
    end
  end

  always_comb begin
    pc_nx    = pc;
    state_nx = state;
    unique case (1'b1)
      (en && rollback_en): begin
        pc_nx    = rollback_PC;
        state_nx = FETCH;
      end
      accept: begin
        pc_nx = if_valid_inst_out[1] ? if_target_out[1]
                                     : if_target_out[0];
        if (halt_hit) state_nx = HALTED;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_if_stage_2way.sv
// Randomized bench for if_stage_2way against a slot-level reference model.
module tb_if_stage_2way;

  localparam logic [31:0] HALT = 32'h0000_0555;

  logic             clock = 1'b0;
  logic             reset, en, fetch_en, rollback_en;
  logic [63:0]      rollback_PC, Icache_data_in;
  logic             Icache_valid_in;
  logic [63:0]      Icache_PC_out;
  logic [1:0][63:0] if_PC_out, if_NPC_out, if_target_out;
  logic [1:0][31:0] if_IR_out;
  logic [1:0]       if_valid_inst_out;
  logic             halted;

  if_stage_2way dut (
    .clock(clock), .reset(reset), .en(en), .fetch_en(fetch_en),
    .rollback_en(rollback_en), .rollback_PC(rollback_PC),
    .Icache_data_in(Icache_data_in), .Icache_valid_in(Icache_valid_in),
    .Icache_PC_out(Icache_PC_out), .if_PC_out(if_PC_out),
    .if_NPC_out(if_NPC_out), .if_IR_out(if_IR_out),
    .if_target_out(if_target_out),
    .if_valid_inst_out(if_valid_inst_out), .halted(halted)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [63:0] m_pc;
  logic        m_halted;
  logic        m_known = 1'b0;
  logic [1:0]  e_valid;
  logic [63:0] e_tgt [2];
  logic [31:0] e_ir [2];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit is_taken(input logic [31:0] ir);
`ifdef IF_PREDECODE_EN
    return ir[31:26] == 6'h30 || ir[31:26] == 6'h34;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_outputs();
    logic [63:0] base, spc;
    longint disp;
    base = m_pc & ~64'h7;
    e_ir[0] = Icache_data_in[31:0];
    e_ir[1] = Icache_data_in[63:32];
    if (m_halted || rollback_en || !Icache_valid_in) e_valid = 2'b00;
    else if (m_pc[2]) e_valid = 2'b10;
    else e_valid = 2'b11;
    for (int i = 0; i < 2; i++) begin
      spc  = base + 64'(4 * i);
      disp = longint'($signed(e_ir[i][20:0])) * 4;
      e_tgt[i] = spc + 4;
      if (e_valid[i] && is_taken(e_ir[i])) e_tgt[i] = spc + 4 + disp;
    end
    if (e_valid[0] && (e_ir[0] == HALT || is_taken(e_ir[0])))
      e_valid[1] = 1'b0;
  endtask

  task automatic compare();
    logic [63:0] base;
    if (!m_known) return;
    model_outputs();
    base = m_pc & ~64'h7;
    chk("icache_pc", Icache_PC_out, base);
    chk("valid", 64'(if_valid_inst_out), 64'(e_valid));
    chk("halted", 64'(halted), 64'(m_halted));
    for (int i = 0; i < 2; i++) begin
      chk("pc", if_PC_out[i], base + 64'(4 * i));
      chk("npc", if_NPC_out[i], base + 64'(4 * i) + 4);
      chk("ir", 64'(if_IR_out[i]), 64'(e_ir[i]));
      if (e_valid[i]) chk("target", if_target_out[i], e_tgt[i]);
    end
  endtask

  task automatic set_in(input logic r, input logic e, input logic fe,
                        input logic rb, input logic [63:0] rbpc,
                        input logic iv, input logic [63:0] d);
    @(negedge clock);
    reset = r; en = e; fetch_en = fe; rollback_en = rb;
    rollback_PC = rbpc; Icache_valid_in = iv; Icache_data_in = d;
    #1;
    compare();
  endtask

  task automatic tick();
    if (m_known) model_outputs();
    @(posedge clock);
    if (reset) begin
      m_pc = 64'h0; m_halted = 1'b0; m_known = 1'b1;
    end else if (!m_known) begin
    end else if (en && rollback_en) begin
      m_pc = rollback_PC; m_halted = 1'b0;
    end else if (en && fetch_en && e_valid != 2'b00) begin
      m_pc = e_valid[1] ? e_tgt[1] : e_tgt[0];
      if ((e_valid[0] && e_ir[0] == HALT) ||
          (e_valid[1] && e_ir[1] == HALT))
        m_halted = 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic fe,
                      input logic rb, input logic [63:0] rbpc,
                      input logic iv, input logic [63:0] d);
    set_in(r, e, fe, rb, rbpc, iv, d);
    tick();
  endtask

  function automatic logic [31:0] rand_inst();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0: return HALT;
      1: return {6'h30, 26'($urandom)};
      2: return {6'h34, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [63:0] rand_pc();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4);
    return {32'($urandom_range(0, 3)), $urandom} & ~64'h3;
  endfunction

  localparam logic [63:0] D1 = {32'h47FF041F, 32'h43E00401};

  initial begin
    reset = 1'b1; en = 1'b0; fetch_en = 1'b0; rollback_en = 1'b0;
    rollback_PC = '0; Icache_valid_in = 1'b0; Icache_data_in = '0;

    step(1, 1, 1, 0, 0, 1, D1);
    set_in(0, 1, 1, 0, 0, 1, D1);
    chk("lit_rst_halted", 64'(halted), 64'd0);
    chk("lit_rst_valid", 64'(if_valid_inst_out), 64'h3);
    chk("lit_rst_pc0", if_PC_out[0], 64'h0);
    chk("lit_rst_pc1", if_PC_out[1], 64'h4);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 0, 0, 1, D1);
      chk("lit_stall_pc", Icache_PC_out, 64'h8);
      chk("lit_stall_valid", 64'(if_valid_inst_out), 64'h3);
      tick();
    end
    step(0, 1, 1, 0, 0, 1, D1);
    set_in(0, 1, 0, 0, 0, 1, D1);
    chk("lit_after_stall", Icache_PC_out, 64'h10);
    tick();

    set_in(0, 1, 1, 1, 64'h14, 1, D1);
    chk("lit_rb_valid", 64'(if_valid_inst_out), 64'h0);
    tick();
    set_in(0, 1, 1, 0, 0, 1, D1);
    chk("lit_mid_valid", 64'(if_valid_inst_out), 64'h2);
    chk("lit_mid_pc1", if_PC_out[1], 64'h14);
    chk("lit_mid_tgt1", if_target_out[1], 64'h18);
    tick();
    set_in(0, 1, 0, 0, 0, 1, D1);
    chk("lit_mid_next", Icache_PC_out, 64'h18);
    tick();

    step(0, 1, 1, 1, 64'h100, 1, D1);
    set_in(0, 1, 0, 0, 0, 1, D1);
    chk("lit_rb100", Icache_PC_out, 64'h100);
    chk("lit_rb100_halted", 64'(halted), 64'd0);
    tick();

    step(0, 1, 1, 1, 64'h20, 1, D1);
    set_in(0, 1, 1, 0, 0, 1, {32'h43E00401, HALT});
    chk("lit_halt_valid", 64'(if_valid_inst_out), 64'h1);
    tick();
    set_in(0, 1, 1, 0, 0, 1, D1);
    chk("lit_halted", 64'(halted), 64'd1);
    chk("lit_halted_valid", 64'(if_valid_inst_out), 64'h0);
    tick();
    step(0, 1, 1, 1, 64'h40, 1, D1);
    set_in(0, 1, 0, 0, 0, 1, D1);
    chk("lit_unhalt", 64'(halted), 64'd0);
    chk("lit_unhalt_pc", Icache_PC_out, 64'h40);
    tick();

    step(0, 1, 1, 1, 64'h0, 1, D1);
    set_in(0, 1, 1, 0, 0, 1, {32'h43E00401, 32'hC3E00003});
`ifdef IF_PREDECODE_EN
    chk("lit_br_valid", 64'(if_valid_inst_out), 64'h1);
    chk("lit_br_tgt0", if_target_out[0], 64'h10);
`else
    chk("lit_br_valid", 64'(if_valid_inst_out), 64'h3);
`endif
    tick();
    set_in(0, 1, 0, 0, 0, 1, D1);
`ifdef IF_PREDECODE_EN
    chk("lit_br_next", Icache_PC_out, 64'h10);
`else
    chk("lit_br_next", Icache_PC_out, 64'h8);
`endif
    tick();

    step(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, D1);
    step(0, 1, 1, 0, 0, 1, D1);
    set_in(0, 1, 0, 0, 0, 1, D1);
    chk("lit_wrap", Icache_PC_out, 64'h0);
    tick();

    step(0, 0, 1, 1, 64'h500, 1, D1);
    set_in(0, 0, 1, 0, 0, 1, D1);
    chk("lit_en_hold", Icache_PC_out, 64'h0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0,
           rand_pc(),
           $urandom_range(0, 4) != 0,
           {rand_inst(), rand_inst()});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
